// File: rtl/mont_modexp_ctrl_pkg.sv
// Shared types and constants for the Montgomery modular-exponentiation sequencer.
package mont_modexp_ctrl_pkg;

    localparam int SIZE_W    = 12;
    localparam int NBITS_DEF = 256;

    // Multiplicand used for domain entry of 1 and for domain exit; cast to NBITS at use.
    localparam logic [NBITS_DEF-1:0] ONE = {{(NBITS_DEF-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV_X,
        ST_CONV_ONE,
        ST_SQUARE,
        ST_MULT,
        ST_CONV_OUT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mont_modexp_ctrl_mm_issue.sv
// Issue/wait handshake toward the Montgomery multiplier: one enable pulse per
// request, operands held until the multiplier's done pulse, result captured.
module mont_mm_issue
    import mont_modexp_ctrl_pkg::*;
#(
    parameter int NBITS = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_p,
    input  logic [NBITS-1:0] op_a,
    input  logic [NBITS-1:0] op_b,
    input  logic [NBITS-1:0] mm_y,
    input  logic             mm_done_p,
    output logic             mm_enable_p,
    output logic [NBITS-1:0] mm_a,
    output logic [NBITS-1:0] mm_b,
    output logic             waiting,
    output logic [NBITS-1:0] y,
    output logic             y_valid_p
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm_enable_p <= 1'b0;
            mm_a        <= '0;
            mm_b        <= '0;
            waiting     <= 1'b0;
            y           <= '0;
            y_valid_p   <= 1'b0;
        end else begin
            mm_enable_p <= 1'b0;
            y_valid_p   <= 1'b0;
            if (issue_p && !waiting) begin
                mm_a        <= op_a;
                mm_b        <= op_b;
                mm_enable_p <= 1'b1;
                waiting     <= 1'b1;
            end else if (waiting && mm_done_p) begin
                // done pulses while not waiting fall through and are ignored
                y         <= mm_y;
                y_valid_p <= 1'b1;
                waiting   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mont_modexp_ctrl.sv
// Left-to-right square-and-multiply modexp sequencer in the Montgomery domain.
// Optional macro MODEXP_SKIP_LEADING_ZEROS_EN: consume leading zero exponent bits without multiplies.
//
// state       | meaning
// ST_IDLE     | waiting for start_p
// ST_CONV_X   | xb  = MM(base, R^2 mod m)
// ST_CONV_ONE | acc = MM(1, R^2 mod m) = R mod m
// ST_SQUARE   | acc = MM(acc, acc) for bit i (or leading-zero scan)
// ST_MULT     | acc = MM(acc, xb) when exp[i] = 1
// ST_CONV_OUT | result = MM(acc, 1)
// ST_DONE     | done_irq_p pulse, back to idle
module mont_modexp_ctrl
    import mont_modexp_ctrl_pkg::*;
#(
    parameter int NBITS = 256,
    parameter int EBITS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_p,
    input  logic [NBITS-1:0]  base,
    input  logic [EBITS-1:0]  exp,
    input  logic [SIZE_W-1:0] exp_size,
    input  logic [NBITS-1:0]  m,
    input  logic [SIZE_W-1:0] m_size,
    input  logic [NBITS-1:0]  r2_mod_m,
    output logic [NBITS-1:0]  result,
    output logic              busy,
    output logic              done_irq_p,
    output logic              mm_enable_p,
    output logic [NBITS-1:0]  mm_a,
    output logic [NBITS-1:0]  mm_b,
    output logic [NBITS-1:0]  mm_m,
    output logic [SIZE_W-1:0] mm_m_size,
    input  logic [NBITS-1:0]  mm_y,
    input  logic              mm_done_p
);

`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    localparam bit SKIP_LZ = 1'b1;
`else
    localparam bit SKIP_LZ = 1'b0;
`endif

    localparam logic [NBITS-1:0] ONE_N = NBITS'(ONE);

    state_t            state, state_nxt;
    logic [NBITS-1:0]  base_q, r2_q, xb, acc, y;
    logic [EBITS-1:0]  exp_q, exp_shift;
    logic [SIZE_W-1:0] exp_size_q, bit_idx;
    logic              leading, cur_bit, last_bit;
    logic              issue_p, waiting, y_valid_p;
    logic [NBITS-1:0]  op_a, op_b;

    assign exp_shift = exp_q >> bit_idx;
    assign cur_bit   = exp_shift[0];
    assign last_bit  = (bit_idx == '0);

    mont_mm_issue #(.NBITS(NBITS)) u_issue (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_p     (issue_p),
        .op_a        (op_a),
        .op_b        (op_b),
        .mm_y        (mm_y),
        .mm_done_p   (mm_done_p),
        .mm_enable_p (mm_enable_p),
        .mm_a        (mm_a),
        .mm_b        (mm_b),
        .waiting     (waiting),
        .y           (y),
        .y_valid_p   (y_valid_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (start_p) state_nxt = ST_CONV_X;
            ST_CONV_X:   if (y_valid_p) state_nxt = ST_CONV_ONE;
            ST_CONV_ONE: if (y_valid_p) state_nxt = (exp_size_q == '0) ? ST_CONV_OUT : ST_SQUARE;
            ST_SQUARE: begin
                if (leading) begin
                    if (last_bit) state_nxt = ST_CONV_OUT;
                end else if (y_valid_p) begin
                    if (cur_bit)       state_nxt = ST_MULT;
                    else if (last_bit) state_nxt = ST_CONV_OUT;
                end
            end
            ST_MULT:     if (y_valid_p) state_nxt = last_bit ? ST_CONV_OUT : ST_SQUARE;
            ST_CONV_OUT: if (y_valid_p) state_nxt = ST_DONE;
            ST_DONE:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // A new request may go out only once the previous result has been consumed.
    always_comb begin
        op_a       = '0;
        op_b       = '0;
        issue_p    = 1'b0;
        busy       = (state != ST_IDLE) && (state != ST_DONE);
        done_irq_p = (state == ST_DONE);
        case (state)
            ST_CONV_X:   begin op_a = base_q; op_b = r2_q; issue_p = 1'b1; end
            ST_CONV_ONE: begin op_a = ONE_N;  op_b = r2_q; issue_p = 1'b1; end
            ST_SQUARE:   begin op_a = acc;    op_b = acc;  issue_p = !leading; end
            ST_MULT:     begin op_a = acc;    op_b = xb;   issue_p = 1'b1; end
            ST_CONV_OUT: begin op_a = acc;    op_b = ONE_N; issue_p = 1'b1; end
            default:     ;
        endcase
        if (waiting || y_valid_p) issue_p = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q     <= '0;
            r2_q       <= '0;
            exp_q      <= '0;
            exp_size_q <= '0;
            mm_m       <= '0;
            mm_m_size  <= '0;
            xb         <= '0;
            acc        <= '0;
            result     <= '0;
            bit_idx    <= '0;
            leading    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_p) begin
                        base_q     <= base;
                        r2_q       <= r2_mod_m;
                        exp_q      <= exp;
                        exp_size_q <= exp_size;
                        mm_m       <= m;
                        mm_m_size  <= m_size;
                        bit_idx    <= exp_size - SIZE_W'(1);
                        leading    <= SKIP_LZ;
                    end
                end
                ST_CONV_X:   if (y_valid_p) xb <= y;
                ST_CONV_ONE: if (y_valid_p) acc <= y;
                ST_SQUARE: begin
                    if (leading) begin
                        // first set bit loads xb directly: 1^2 * x needs no multiply
                        if (cur_bit) begin
                            acc     <= xb;
                            leading <= 1'b0;
                        end
                        if (!last_bit) bit_idx <= bit_idx - SIZE_W'(1);
                    end else if (y_valid_p) begin
                        acc <= y;
                        if (!cur_bit && !last_bit) bit_idx <= bit_idx - SIZE_W'(1);
                    end
                end
                ST_MULT: begin
                    if (y_valid_p) begin
                        acc <= y;
                        if (!last_bit) bit_idx <= bit_idx - SIZE_W'(1);
                    end
                end
                ST_CONV_OUT: if (y_valid_p) result <= y;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_modexp_ctrl.sv
// Self-checking bench for mont_modexp_ctrl with NBITS=EBITS=8 and a behavioural
// Montgomery multiplier responder (fixed latency) on the downstream side.
module tb_mont_modexp_ctrl;

    localparam int NB = 8;
    localparam int EB = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_p;
    logic [NB-1:0] base, m, r2_mod_m, result, mm_a, mm_b, mm_m, mm_y;
    logic [EB-1:0] exp;
    logic [11:0]   exp_size, m_size, mm_m_size;
    logic          busy, done_irq_p, mm_enable_p, mm_done_p;
    logic          model_done, spur_done;
    logic [NB-1:0] mdl_a, mdl_b;
    int            mdl_cnt;
    int            mult_total = 0;
    int            n_total = 0;
    int            n_pass = 0;

    always #5 clk = ~clk;

    assign mm_done_p = model_done | spur_done;

    mont_modexp_ctrl #(.NBITS(NB), .EBITS(EB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_p     (start_p),
        .base        (base),
        .exp         (exp),
        .exp_size    (exp_size),
        .m           (m),
        .m_size      (m_size),
        .r2_mod_m    (r2_mod_m),
        .result      (result),
        .busy        (busy),
        .done_irq_p  (done_irq_p),
        .mm_enable_p (mm_enable_p),
        .mm_a        (mm_a),
        .mm_b        (mm_b),
        .mm_m        (mm_m),
        .mm_m_size   (mm_m_size),
        .mm_y        (mm_y),
        .mm_done_p   (mm_done_p)
    );

    // Bit-serial Montgomery product a*b*2^-ms mod md.
    function automatic logic [NB-1:0] mm_f(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                           input logic [NB-1:0] md, input int ms);
        logic [NB+1:0] t;
        t = '0;
        for (int i = 0; i < ms; i++) begin
            if (a[i]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, md};
            t = t >> 1;
        end
        if (t >= {2'b00, md}) t = t - {2'b00, md};
        return t[NB-1:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_cnt    <= 0;
            model_done <= 1'b0;
            mm_y       <= '0;
        end else begin
            model_done <= 1'b0;
            if (mm_enable_p) begin
                mdl_a      <= mm_a;
                mdl_b      <= mm_b;
                mdl_cnt    <= 3;
                mult_total <= mult_total + 1;
            end else if (mdl_cnt == 1) begin
                model_done <= 1'b1;
                mm_y       <= mm_f(mdl_a, mdl_b, mm_m, int'(mm_m_size));
                mdl_cnt    <= 0;
            end else if (mdl_cnt > 1) begin
                mdl_cnt <= mdl_cnt - 1;
            end
        end
    end

    typedef struct {
        logic [NB-1:0] base;
        logic [EB-1:0] exp;
        logic [11:0]   exp_size;
        logic [NB-1:0] res;
        int            mults_full;
        int            mults_skip;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, want);
    endtask

    function automatic int want_mults(input vec_t v);
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
        return v.mults_skip;
`else
        return v.mults_full;
`endif
    endfunction

    // Runs one exponentiation; restart_at >= 0 pulses start_p again mid-run with other operands.
    task automatic run_op(input vec_t v, input int restart_at, input string tag,
                          output logic [NB-1:0] res, output int mults, output int dones,
                          output bit ok);
        int snap;
        @(negedge clk);
        base = v.base; exp = v.exp; exp_size = v.exp_size; start_p = 1'b1;
        snap = mult_total;
        @(negedge clk);
        start_p = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_mm_m"}, 32'(mm_m), 32'd13);
        ok = 1'b0; res = '0; dones = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (done_irq_p) begin
                ok = 1'b1; res = result; dones = 1;
                break;
            end
            if (cyc == restart_at) begin
                base = 8'd7; exp = 8'd3; exp_size = 12'd2; start_p = 1'b1;
                @(negedge clk);
                start_p = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done_irq_p) dones++;
        end
        mults = mult_total - snap;
    endtask

    initial begin
        logic [NB-1:0] res;
        int            mults, dones, snap, bound;
        bit            ok;
        bit            saw_done;

        vecs[0] = '{base: 8'd2,  exp: 8'd5,    exp_size: 12'd4, res: 8'd6,  mults_full: 9,  mults_skip: 6};
        vecs[1] = '{base: 8'd2,  exp: 8'd12,   exp_size: 12'd4, res: 8'd1,  mults_full: 9,  mults_skip: 7};
        vecs[2] = '{base: 8'd7,  exp: 8'd0,    exp_size: 12'd4, res: 8'd1,  mults_full: 7,  mults_skip: 3};
        vecs[3] = '{base: 8'd7,  exp: 8'd0,    exp_size: 12'd0, res: 8'd1,  mults_full: 3,  mults_skip: 3};
        vecs[4] = '{base: 8'd0,  exp: 8'd3,    exp_size: 12'd2, res: 8'd0,  mults_full: 7,  mults_skip: 5};
        vecs[5] = '{base: 8'd5,  exp: 8'd13,   exp_size: 12'd4, res: 8'd5,  mults_full: 10, mults_skip: 8};
        vecs[6] = '{base: 8'd12, exp: 8'd3,    exp_size: 12'd4, res: 8'd12, mults_full: 9,  mults_skip: 5};
        vecs[7] = '{base: 8'd2,  exp: 8'hF5,   exp_size: 12'd4, res: 8'd6,  mults_full: 9,  mults_skip: 6};

        rst_n = 1'b0; start_p = 1'b0; spur_done = 1'b0;
        base = '0; exp = '0; exp_size = '0;
        m = 8'd13; m_size = 12'd4; r2_mod_m = 8'd9;
        repeat (3) @(negedge clk);
        check("rst_result", 32'(result), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done_irq_p), 32'd0);
        check("rst_mm_en", 32'(mm_enable_p), 32'd0);
        check("rst_mm_a", 32'(mm_a), 32'd0);
        check("rst_mm_m_size", 32'(mm_m_size), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i], -1, $sformatf("v%0d", i), res, mults, dones, ok);
            check($sformatf("v%0d_finished", i), 32'(ok), 32'd1);
            check($sformatf("v%0d_result", i), 32'(res), 32'(vecs[i].res));
            check($sformatf("v%0d_mults", i), 32'(mults), 32'(want_mults(vecs[i])));
            check($sformatf("v%0d_done_pulses", i), 32'(dones), 32'd1);
            check($sformatf("v%0d_idle_after", i), 32'(busy), 32'd0);
        end

        // second start_p mid-run must not disturb the operation in flight
        run_op(vecs[0], 5, "restart", res, mults, dones, ok);
        check("restart_finished", 32'(ok), 32'd1);
        check("restart_result", 32'(res), 32'd6);
        check("restart_mults", 32'(mults), 32'(want_mults(vecs[0])));
        check("restart_done_pulses", 32'(dones), 32'd1);

        // spurious multiplier done while idle
        snap = mult_total;
        saw_done = 1'b0;
        @(negedge clk); spur_done = 1'b1;
        @(negedge clk); spur_done = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done_irq_p || busy) saw_done = 1'b1;
        end
        check("spur_no_activity", 32'(saw_done), 32'd0);
        check("spur_no_mults", 32'(mult_total - snap), 32'd0);
        check("spur_result_held", 32'(result), 32'd6);

        // async reset while squaring
        @(negedge clk);
        base = 8'd2; exp = 8'd5; exp_size = 12'd4; start_p = 1'b1;
        snap = mult_total;
        @(negedge clk);
        start_p = 1'b0;
        bound = 0;
        while ((mult_total - snap) < 3 && bound < 300) begin
            @(negedge clk);
            bound++;
        end
        check("rst_mid_reached_square", 32'(bound < 300), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_result", 32'(result), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_mm_en", 32'(mm_enable_p), 32'd0);
        check("rst_mid_mm_a", 32'(mm_a), 32'd0);
        check("rst_mid_mm_b", 32'(mm_b), 32'd0);
        check("rst_mid_mm_m", 32'(mm_m), 32'd0);
        check("rst_mid_mm_m_size", 32'(mm_m_size), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(vecs[0], -1, "post_rst", res, mults, dones, ok);
        check("post_rst_finished", 32'(ok), 32'd1);
        check("post_rst_result", 32'(res), 32'd6);
        check("post_rst_mults", 32'(mults), 32'(want_mults(vecs[0])));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
